bram_sum_reader: RTL and testbench
==================================

BRAM_SUM_READER -- requirements
Module: bram_sum_reader

Interface
REQ-001 Parameters: ADDR_W, default 8, RAM address width; DATA_W, default 16, RAM word and result width.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a read pass; sampled only in IDLE.
REQ-005 base_addr  input  ADDR_W  first address to read; captured when start is accepted.
REQ-006 len  input  ADDR_W+1  number of words to read (0..2^ADDR_W); captured when start is accepted.
REQ-007 ram_en  output  1  BRAM read enable, registered.
REQ-008 ram_addr  output  ADDR_W  BRAM read address, registered.
REQ-009 ram_dout  input  DATA_W  BRAM read data, valid exactly one cycle after the edge that sampled ram_en=1.
REQ-010 busy  output  1  high from start acceptance until done is asserted.
REQ-011 done  output  1  one-cycle pulse at pass completion.
REQ-012 result  output  DATA_W  sum of words read, modulo 2^DATA_W; held until the next accepted start.
REQ-013 ovf  output  1  sticky flag; set if any addition in the pass carried out of DATA_W.

Function
REQ-014 FSM states IDLE, READ, DRAIN, DONE; encoding is free.
REQ-015 IDLE: start=1 captures base_addr and len, clears result and ovf, sets busy, and goes to READ; if len=0, goes directly to DONE instead.
REQ-016 READ: ram_en=1 with ram_addr = base_addr+i for i=0..len-1, one address per cycle, no gaps; after the last issue go to DRAIN.
REQ-017 Address arithmetic is modulo 2^ADDR_W; base_addr+i wraps past the top address to 0.
REQ-018 Each ram_dout word is added to result in the cycle it is valid; the carry-out of each addition ORs into ovf.
REQ-019 DRAIN: ram_en=0; accumulate the final word, then go to DONE.
REQ-020 DONE: done=1 for exactly one cycle, busy=0 in the same cycle, result final; next state IDLE.
REQ-021 Latency: with start accepted at edge T, ram_en is high on cycles T+1..T+len, done is high on cycle T+len+2; len=0 gives done at T+1 and result 0.
REQ-022 start while busy, or in the DONE cycle, is ignored and not queued.
REQ-023 ram_en is never high outside READ; ram_addr holds its last value when ram_en=0.
REQ-024 base_addr and len changes after acceptance do not affect the pass in progress.

Reset
REQ-025 rst=1 at a rising edge forces IDLE; ram_en=0, ram_addr=0, busy=0, done=0, result=0, ovf=0.
REQ-026 Reset mid-pass aborts the pass with no done pulse; a RAM word returning in the cycle after reset is discarded.
REQ-027 rst has priority over start in the same cycle.

Configuration
REQ-028 Macro BRAM_RD_MAX_EN: when defined, adds output max_val (DATA_W, unsigned), cleared at start acceptance and reset, holding the largest word read in the pass, final in the done cycle.
REQ-029 Without BRAM_RD_MAX_EN, the max_val port and its logic are absent; all other behaviour is identical.

Verification
REQ-030 RAM[0..3]=1,2,3,4; start with base=0, len=4 -> ram_en high 4 cycles at addr 0,1,2,3; done at T+6; result=10; ovf=0.
REQ-031 ADDR_W=8; base=254, len=4; RAM[254]=5, RAM[255]=6, RAM[0]=7, RAM[1]=8 -> addresses 254,255,0,1; result=26.
REQ-032 DATA_W=16; RAM[0]=0xFFFF, RAM[1]=0x0002; len=2 -> result=0x0001; ovf=1.
REQ-033 len=0 -> no ram_en; done at T+1; result=0; a second start during a len=8 pass -> ignored, exactly one done pulse.
REQ-034 rst asserted at T+3 of a len=8 pass -> no done; all outputs 0 on the next cycle; a new pass afterwards produces the correct sum.
REQ-035 With BRAM_RD_MAX_EN: words 3,9,2 -> max_val=9 at done; without the macro the design elaborates with no max_val port.

Source files
------------

// File: rtl/bram_sum_reader.sv
// Reads len consecutive BRAM words starting at base_addr and sums them modulo 2^DATA_W.
// Optional feature macro: BRAM_RD_MAX_EN adds max_val, the largest word read in the pass.
module bram_sum_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ovf
`ifdef BRAM_RD_MAX_EN
  ,
  output logic [DATA_W-1:0] max_val
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W:0]     remain_r;
  logic                rd_valid_r;
  logic                accept_s;
  logic                last_issue_s;
  logic [DATA_W:0]     sum_s;

  // remain_r counts issues still outstanding after the current one
  // Next-state and acceptance decode
  always_comb begin
    state_s      = state_r;
    accept_s     = 1'b0;
    last_issue_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          if (len == {(ADDR_W+1){1'b0}}) begin
            state_s = DONE;
          end else begin
            state_s = READ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (remain_r == {(ADDR_W+1){1'b0}}) begin
          last_issue_s = 1'b1;
          state_s      = DRAIN;
        end else begin
          state_s = READ;
        end
      end
      DRAIN:   state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered control outputs and read address generation
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en     <= 1'b0;
      ram_addr   <= {ADDR_W{1'b0}};
      remain_r   <= {(ADDR_W+1){1'b0}};
      rd_valid_r <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      ram_en     <= (state_s == READ);
      busy       <= (state_s == READ) || (state_s == DRAIN);
      done       <= (state_s == DONE);
      rd_valid_r <= ram_en;
      if (accept_s && (len != {(ADDR_W+1){1'b0}})) begin
        ram_addr <= base_addr;
        remain_r <= len - (ADDR_W+1)'(1);
      end else if ((state_r == READ) && !last_issue_s) begin
        ram_addr <= ram_addr + ADDR_W'(1);
        remain_r <= remain_r - (ADDR_W+1)'(1);
      end else begin
        ram_addr <= ram_addr;
        remain_r <= remain_r;
      end
    end
  end

  assign sum_s = {1'b0, result} + {1'b0, ram_dout};

  // Sum accumulator; rd_valid_r marks the cycle a requested word is on ram_dout
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= {DATA_W{1'b0}};
      ovf    <= 1'b0;
    end else if (accept_s) begin
      result <= {DATA_W{1'b0}};
      ovf    <= 1'b0;
    end else if (rd_valid_r) begin
      result <= sum_s[DATA_W-1:0];
      ovf    <= ovf | sum_s[DATA_W];
    end else begin
      result <= result;
      ovf    <= ovf;
    end
  end

`ifdef BRAM_RD_MAX_EN
  // Running maximum of the words read in the pass
  always_ff @(posedge clk) begin
    if (rst) begin
      max_val <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      max_val <= {DATA_W{1'b0}};
    end else if (rd_valid_r && (ram_dout > max_val)) begin
      max_val <= ram_dout;
    end else begin
      max_val <= max_val;
    end
  end
`endif

endmodule

// File: tb/tb_bram_sum_reader.sv
// Self-checking bench for bram_sum_reader: pass-level reference model checked every cycle,
// plus directed passes with hand-computed literal results.
module tb_bram_sum_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  len;
  logic        ram_en;
  logic [7:0]  ram_addr;
  logic [15:0] ram_dout;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ovf;
`ifdef BRAM_RD_MAX_EN
  logic [15:0] max_val;
`endif

  logic [15:0] mem [256];

  int n_cmp = 0;
  int n_bad = 0;

  bram_sum_reader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .busy(busy), .done(done), .result(result), .ovf(ovf)
`ifdef BRAM_RD_MAX_EN
    , .max_val(max_val)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM with one-cycle read latency
  always @(posedge clk) begin
    if (ram_en === 1'b1) ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- pass-level reference model ----------------
  int          cyc = 0;
  bit          m_active = 1'b0;
  int          m_T = 0;
  int          m_len = 0;
  int          md;
  logic [7:0]  m_base;
  logic [15:0] m_sum, m_res, m_max, m_maxv;
  bit          m_ovf, m_ovfv;
  logic [7:0]  m_last_addr;
  logic [7:0]  ma;
  logic [16:0] mt;

  function automatic int done_d(input int l);
    return (l == 0) ? 0 : l + 1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_active = 1'b0; m_res = 16'd0; m_ovfv = 1'b0; m_last_addr = 8'd0; m_maxv = 16'd0;
    end else begin
      if (m_active) begin
        if (cyc - m_T == done_d(m_len) + 1) m_active = 1'b0;
      end else if (start) begin
        m_active = 1'b1; m_T = cyc; m_base = base_addr; m_len = int'(len);
        m_res = 16'd0; m_ovfv = 1'b0; m_maxv = 16'd0;
        m_sum = 16'd0; m_ovf = 1'b0; m_max = 16'd0;
        for (int i = 0; i < m_len; i++) begin
          ma = m_base + 8'(i);
          mt = {1'b0, m_sum} + {1'b0, mem[ma]};
          m_sum = mt[15:0];
          m_ovf = m_ovf | mt[16];
          if (mem[ma] > m_max) m_max = mem[ma];
        end
      end
      if (m_active) begin
        md = cyc - m_T;
        if (md < m_len) m_last_addr = m_base + 8'(md);
        if (md == done_d(m_len)) begin
          m_res = m_sum; m_ovfv = m_ovf; m_maxv = m_max;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  int  cd;
  bit  e_en, e_busy, e_done;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      cd     = cyc - m_T;
      e_en   = m_active && (m_len != 0) && (cd < m_len);
      e_busy = m_active && (m_len != 0) && (cd <= m_len);
      e_done = m_active && (cd == done_d(m_len));
      chk("ram_en", 32'(ram_en), 32'(e_en));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("ram_addr", 32'(ram_addr), 32'(m_last_addr));
      if (!e_busy) begin
        chk("result", 32'(result), 32'(m_res));
        chk("ovf", 32'(ovf), 32'(m_ovfv));
      end
`ifdef BRAM_RD_MAX_EN
      if (e_done) chk("max_val", 32'(max_val), 32'(m_maxv));
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  int cnt;
  int ndone;

  task automatic do_pass(input logic [7:0] b, input logic [8:0] l, output int c);
    @(negedge clk); start = 1'b1; base_addr = b; len = l;
    @(negedge clk); start = 1'b0; base_addr = ~b; len = 9'h1FF;
    c = 1;
    while (done !== 1'b1 && c < 400) begin
      @(negedge clk); c++;
    end
    if (done !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done expected done within 400 cycles");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 37 + 5);
    rst = 1'b1; start = 1'b0; base_addr = 8'd0; len = 9'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    rst = 1'b0;

    // Basic four-word sum
    mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3; mem[3] = 16'd4;
    do_pass(8'd0, 9'd4, cnt);
    chk("basic_latency", 32'(cnt), 32'd6);
    chk("basic_result", 32'(result), 32'd10);
    chk("basic_ovf", 32'(ovf), 32'd0);

    // Address wrap past the top
    mem[254] = 16'd5; mem[255] = 16'd6; mem[0] = 16'd7; mem[1] = 16'd8;
    do_pass(8'd254, 9'd4, cnt);
    chk("wrap_result", 32'(result), 32'd26);

    // Carry out of the sum
    mem[0] = 16'hFFFF; mem[1] = 16'h0002;
    do_pass(8'd0, 9'd2, cnt);
    chk("ovf_latency", 32'(cnt), 32'd4);
    chk("ovf_result", 32'(result), 32'h0001);
    chk("ovf_flag", 32'(ovf), 32'd1);

    // Zero-length pass clears result and ovf
    do_pass(8'd9, 9'd0, cnt);
    chk("len0_latency", 32'(cnt), 32'd1);
    chk("len0_result", 32'(result), 32'd0);
    chk("len0_ovf", 32'(ovf), 32'd0);

    // Start while busy and start in the done cycle are both ignored
    @(negedge clk); start = 1'b1; base_addr = 8'd0; len = 9'd8;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; base_addr = 8'd50; len = 9'd2;
    @(negedge clk); start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        ndone++;
        start = 1'b1; base_addr = 8'd60; len = 9'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("single_done", 32'(ndone), 32'd1);

    // Reset in the middle of a pass
    @(negedge clk); start = 1'b1; base_addr = 8'd10; len = 9'd8;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_addr", 32'(ram_addr), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    mem[10] = 16'd100; mem[11] = 16'd200; mem[12] = 16'd300;
    do_pass(8'd10, 9'd3, cnt);
    chk("post_rst_result", 32'(result), 32'd600);

    // Reset wins over start in the same cycle
    @(negedge clk); rst = 1'b1; start = 1'b1; base_addr = 8'd0; len = 9'd4;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_prio_busy", 32'(busy), 32'd0);

    // Max-value tracking and a full-depth pass
    mem[20] = 16'd3; mem[21] = 16'd9; mem[22] = 16'd2;
    do_pass(8'd20, 9'd3, cnt);
    chk("max_pass_result", 32'(result), 32'd14);
`ifdef BRAM_RD_MAX_EN
    chk("max_val_lit", 32'(max_val), 32'd9);
`endif
    do_pass(8'd100, 9'd256, cnt);
    chk("full_latency", 32'(cnt), 32'd258);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
